// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
// The state enum is used by the controller FSM; the constants by the controller and packer.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSN   = 32'h00000013;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs loader bytes big-endian into a 32-bit word; word_full flags the transfer
// that completes a word, so the controller can move to its write cycle.
module imem_word_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;

  // clear only rewinds the byte count; stale bytes are shifted out by the next word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg <= '0;
      word_reg     <= '0;
    end else if (clear) begin
      byte_cnt_reg <= '0;
    end else if (shift_en) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      word_reg     <= {word_reg[23:0], byte_in};
    end
  end

  assign word_full = shift_en && (byte_cnt_reg == 2'(WORD_BYTES - 1));
  assign word      = word_reg;

endmodule

// File: rtl/imem_load_ctrl.sv
// Arbitrates the instruction RAM port between CPU fetch and a byte-serial program
// loader; while a load session runs the CPU is stalled and fed NOPs.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic [ADDR_WIDTH:0]   load_words,
  input  logic                  load_abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic [31:0]           cpu_iaddr,
  output logic [31:0]           cpu_idata,
  output logic                  cpu_hold,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   widx_reg;
  logic [ADDR_WIDTH:0]   widx_next;
  logic [ADDR_WIDTH:0]   sat_words;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  word_full;
  logic                  unused_iaddr_bits;

  assign sat_words = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
  assign widx_next = widx_reg + 1'b1;
  assign wr_addr   = base_reg + widx_reg[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      base_reg  <= '0;
      count_reg <= '0;
      widx_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && load_start) begin
        base_reg  <= load_base;
        count_reg <= sat_words;
        widx_reg  <= '0;
      end else if (state_reg == ST_WRITE && !load_abort) begin
        widx_reg  <= widx_next;
      end
    end
  end

  imem_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_reg == ST_IDLE),
    .shift_en  (byte_valid && byte_ready),
    .byte_in   (byte_data),
    .word      (mem_wdata),
    .word_full (word_full)
  );

  // abort suppresses the write strobe and done pulse in the same cycle it is seen
  assign byte_ready = (state_reg == ST_COLLECT);
  assign mem_we     = (state_reg == ST_WRITE) && !load_abort;
  assign done       = (state_reg == ST_DONE) && !load_abort;
  assign busy       = (state_reg != ST_IDLE);
  assign cpu_hold   = busy;

  always_comb begin
    state_next = state_reg;
    mem_addr   = cpu_iaddr[ADDR_WIDTH+1:2];
    cpu_idata  = NOP_INSN;
    case (state_reg)
      ST_IDLE: begin
        cpu_idata = mem_rdata;
        if (load_start) state_next = (sat_words == '0) ? ST_DONE : ST_COLLECT;
      end
      ST_COLLECT: begin
        mem_addr = wr_addr;
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_addr   = wr_addr;
        state_next = (widx_next == count_reg) ? ST_DONE : ST_COLLECT;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (state_reg != ST_IDLE && load_abort) state_next = ST_IDLE;
  end

  assign unused_iaddr_bits = ^{cpu_iaddr[31:ADDR_WIDTH+2], cpu_iaddr[1:0]};

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized bench for imem_load_ctrl: a transaction-level model predicts the words
// each load session should write, and a bench-side RAM closes the loop via CPU reads.
module tb_imem_load_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_words;
  logic          load_abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [31:0]   cpu_iaddr;
  logic [31:0]   cpu_idata;
  logic          cpu_hold;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  imem_load_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_base  (load_base),
    .load_words (load_words),
    .load_abort (load_abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .cpu_iaddr  (cpu_iaddr),
    .cpu_idata  (cpu_idata),
    .cpu_hold   (cpu_hold),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done)
  );

  // Bench-side instruction RAM with combinational read
  logic [31:0] tb_mem [DEPTH];
  logic        force_rdata_en = 1'b0;
  logic [31:0] force_rdata    = '0;
  assign mem_rdata = force_rdata_en ? force_rdata : tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

  int checks_cnt = 0;
  int errors_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: log writes and done pulses, check the CPU-side view every cycle
  typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t wr_q[$];
  int  done_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) wr_q.push_back('{cyc: cyc, addr: mem_addr, data: mem_wdata});
      if (done) done_q.push_back(cyc);
      if (busy) begin
        check_value("nop_while_busy", cpu_idata, NOP);
        check_value("hold_while_busy", cpu_hold, 1);
      end else begin
        check_value("hold_idle", cpu_hold, 0);
        check_value("we_idle", mem_we, 0);
        check_value("ready_idle", byte_ready, 0);
      end
    end
  end

  // Reference model: expected RAM image and the list of addresses it covers
  logic [31:0] exp_mem [DEPTH];
  int          written_q[$];
  logic [7:0]  fixed_q[$];

  task automatic run_session(input string tag, input int base, input int words,
                             input int abort_after, input int gap_max, input bit start_mid);
    int eff, nbytes, nexp, start_cyc, gap, addr;
    bit acc, got_done;
    logic [7:0]  b;
    logic [7:0]  q[$];
    logic [31:0] w;
    eff    = (words > DEPTH) ? DEPTH : words;
    nbytes = (abort_after >= 0) ? abort_after : eff * 4;
    wr_q.delete();
    done_q.delete();

    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = AW'(base);
    load_words = (AW+1)'(words);
    @(posedge clk); #1;
    load_start = 1'b0;
    start_cyc  = cyc;
    check_value({tag, "_busy_after_start"}, busy, 1);
    check_value({tag, "_hold_after_start"}, cpu_hold, 1);

    for (int i = 0; i < nbytes; i++) begin
      if (start_mid && i == 2) begin
        load_start = 1'b1;
        load_words = (AW+1)'($urandom_range(1, 7));
        load_base  = AW'($urandom);
      end
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (gap) begin
        byte_valid = 1'b0;
        @(posedge clk); #1;
      end
      b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
      byte_valid = 1'b1;
      byte_data  = b;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        acc = byte_ready;
        @(posedge clk); #1;
      end
      if (start_mid && i == 2) load_start = 1'b0;
      if (!acc) begin
        check_value({tag, "_byte_accept_timeout"}, 0, 1);
        break;
      end
      q.push_back(b);
    end
    byte_valid = 1'b0;
    load_start = 1'b0;

    if (abort_after >= 0) begin
      load_abort = 1'b1;
      @(posedge clk); #1;
      load_abort = 1'b0;
      check_value({tag, "_idle_after_abort"}, busy, 0);
    end else begin
      got_done = 1'b0;
      for (int t = 0; t < 30 && !got_done; t++) begin
        @(negedge clk);
        got_done = done;
      end
      check_value({tag, "_done_seen"}, got_done, 1);
      @(negedge clk);
      check_value({tag, "_hold_after_done"}, cpu_hold, 0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Writes expected: one per completed word; an abort landing in a write cycle cancels it
    if (abort_after < 0)                              nexp = eff;
    else if (abort_after > 0 && abort_after % 4 == 0) nexp = abort_after / 4 - 1;
    else                                              nexp = abort_after / 4;

    check_value({tag, "_write_count"}, wr_q.size(), nexp);
    for (int k = 0; k < nexp; k++) begin
      addr = (base + k) % DEPTH;
      w = {q[4*k], q[4*k+1], q[4*k+2], q[4*k+3]};
      exp_mem[addr] = w;
      written_q.push_back(addr);
      if (k < wr_q.size()) begin
        check_value({tag, "_wr_addr"}, wr_q[k].addr, addr);
        check_value({tag, "_wr_data"}, wr_q[k].data, w);
        if (gap_max == 0 && k > 0)
          check_value({tag, "_wr_spacing"}, wr_q[k].cyc - wr_q[k-1].cyc, 5);
      end
    end
    check_value({tag, "_done_count"}, done_q.size(), (abort_after < 0) ? 1 : 0);
    if (abort_after < 0 && done_q.size() > 0) begin
      if (eff == 0)
        check_value({tag, "_done_after_start"}, done_q[0], start_cyc);
      else if (wr_q.size() > 0)
        check_value({tag, "_done_after_write"}, done_q[0], wr_q[wr_q.size()-1].cyc + 1);
    end
    check_value({tag, "_busy_end"}, busy, 0);
    $display("session %s: base=0x%0h words=%0d abort_after=%0d bytes=%0d writes=%0d expected=%0d",
             tag, base, words, abort_after, q.size(), wr_q.size(), nexp);
  endtask

  initial begin
    int a, s_words, s_abort;
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_base  = '0;
    load_words = '0;
    load_abort = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    cpu_iaddr  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_value("rst_byte_ready", byte_ready, 0);
    check_value("rst_mem_we", mem_we, 0);
    check_value("rst_mem_wdata", mem_wdata, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_cpu_hold", cpu_hold, 0);
    rst_n = 1'b1;

    // Idle passthrough of a fetch
    @(posedge clk); #1;
    force_rdata_en = 1'b1;
    force_rdata    = 32'hDEADBEEF;
    cpu_iaddr      = 32'h0000_0008;
    #1;
    check_value("idle_mem_addr", mem_addr, 2);
    check_value("idle_cpu_idata", cpu_idata, 32'hDEADBEEF);
    check_value("idle_mem_we", mem_we, 0);
    $display("passthrough: iaddr=0x%0h mem_addr=0x%0h idata=0x%0h", cpu_iaddr, mem_addr, cpu_idata);
    force_rdata_en = 1'b0;

    fixed_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_session("two_word", 'h10, 2, -1, 0, 1'b0);
    run_session("wrap", 'h3FF, 2, -1, 0, 1'b0);
    run_session("abort6", $urandom_range(0, DEPTH-1), 3, 6, 0, 1'b0);
    run_session("abort_in_write", $urandom_range(0, DEPTH-1), 3, 8, 0, 1'b0);
    run_session("zero_words", $urandom_range(0, DEPTH-1), 0, -1, 0, 1'b0);
    run_session("start_while_busy", $urandom_range(0, DEPTH-1), 2, -1, 1, 1'b1);
    run_session("saturate", $urandom_range(0, DEPTH-1), 2047, -1, 0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      s_words = $urandom_range(0, 5);
      s_abort = (s_words > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, s_words * 4) : -1;
      run_session($sformatf("rand%0d", n), $urandom_range(0, DEPTH-1), s_words, s_abort,
                  $urandom_range(0, 2), (s_words >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset in the middle of collecting, with the loader still offering bytes
    wr_q.delete();
    @(posedge clk); #1;
    load_start = 1'b1;
    load_base  = AW'($urandom);
    load_words = 3;
    @(posedge clk); #1;
    load_start = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_value("mid_rst_byte_ready", byte_ready, 0);
    check_value("mid_rst_busy", busy, 0);
    check_value("mid_rst_mem_we", mem_we, 0);
    check_value("mid_rst_mem_wdata", mem_wdata, 0);
    check_value("mid_rst_hold", cpu_hold, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check_value("post_rst_writes", wr_q.size(), 0);
    check_value("post_rst_busy", busy, 0);
    $display("reset mid-session: writes after release=%0d", wr_q.size());

    // Read back loaded words through the CPU fetch path
    for (int n = 0; n < 16 && written_q.size() > 0; n++) begin
      a = written_q[$urandom_range(0, written_q.size() - 1)];
      @(posedge clk); #1;
      cpu_iaddr = {20'($urandom), AW'(a), 2'($urandom)};
      #1;
      check_value("readback_addr", mem_addr, a);
      check_value("readback_data", cpu_idata, exp_mem[a]);
      $display("readback: addr=0x%0h data=0x%0h expected=0x%0h", a, cpu_idata, exp_mem[a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
